// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register slice.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHL  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_LOAD = 2'd3
  } shift_mode_t;

  // Counter width: clog2 of the register width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_reg_univ_cell.sv
// One register bit: 4:1 next-state mux (hold / lsb-side / msb-side / parallel)
// into a flop with synchronous reset and clock enable.
module shift_cell
  import shift_reg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       rst_val_i,
  input  logic       lo_i,
  input  logic       hi_i,
  input  logic       par_i,
  output logic       bit_o
);

  shift_mode_t mode_e;
  logic        bit_d;
  logic        bit_q;

  assign mode_e = shift_mode_t'(mode_i);

  always_comb begin
    bit_d = bit_q;
    case (mode_e)
      MODE_SHL:  bit_d = lo_i;
      MODE_SHR:  bit_d = hi_i;
      MODE_LOAD: bit_d = par_i;
      default:   bit_d = bit_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_q <= rst_val_i;
    end else if (en_i) begin
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/SHL/SHR/LOAD, serial in/out both ends,
// word counter with registered word_done. Rotate enabled by SHIFT_REG_ROTATE_EN.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter  int unsigned         WIDTH     = 4,
  parameter  logic [WIDTH-1:0]    RESET_VAL = '0,
  localparam int unsigned         CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             rot,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    cnt,
  output logic             word_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  shift_mode_t      mode_e;
  logic             ser_l;
  logic             ser_r;
  logic [WIDTH-1:0] lo_vec;
  logic [WIDTH-1:0] hi_vec;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic             done_d, done_q;

  assign mode_e = shift_mode_t'(mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign ser_l = rot ? q[WIDTH-1] : sin_lsb;
  assign ser_r = rot ? q[0]       : sin_msb;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign ser_l      = sin_lsb;
  assign ser_r      = sin_msb;
`endif

  // lo_vec[i]/hi_vec[i] are the values bit i takes on SHL/SHR respectively.
  assign lo_vec = {q[WIDTH-2:0], ser_l};
  assign hi_vec = {ser_r, q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_cell u_cell (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .mode_i    (mode),
      .rst_val_i (RESET_VAL[i]),
      .lo_i      (lo_vec[i]),
      .hi_i      (hi_vec[i]),
      .par_i     (par_in[i]),
      .bit_o     (q[i])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode_e)
        MODE_SHL, MODE_SHR: begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        MODE_LOAD: cnt_d = '0;
        default:   cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt       = cnt_q;
  assign word_done = done_q;
  assign sout_msb  = q[WIDTH-1];
  assign sout_lsb  = q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ; rotate expectations follow SHIFT_REG_ROTATE_EN.
module tb_shift_reg_univ;

  localparam int W  = 4;
  localparam int CW = 2;

  typedef struct {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, en, sin_lsb, sin_msb, rot;
  logic [1:0]    mode;
  logic [W-1:0]  par_in;
  logic [W-1:0]  q;
  logic          sout_msb, sout_lsb, word_done;
  logic [CW-1:0] cnt;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [W-1:0]  m_q    = '0;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_done = 1'b0;
  bit            rot_en;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sin_lsb   (sin_lsb),
    .sin_msb   (sin_msb),
    .rot       (rot),
    .par_in    (par_in),
    .q         (q),
    .sout_msb  (sout_msb),
    .sout_lsb  (sout_lsb),
    .cnt       (cnt),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, queue its result.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic sl, input logic sm, input logic ro,
                      input logic [W-1:0] p);
    exp_t x;
    logic fl, fr;
    @(negedge clk);
    rst = r; en = e; mode = m; sin_lsb = sl; sin_msb = sm; rot = ro; par_in = p;
    fl = (rot_en && ro) ? m_q[W-1] : sl;
    fr = (rot_en && ro) ? m_q[0]   : sm;
    if (r) begin
      m_q = '0; m_cnt = '0; m_done = 1'b0;
    end else if (!e || m == 2'd0) begin
      m_done = 1'b0;
    end else if (m == 2'd3) begin
      m_q = p; m_cnt = '0; m_done = 1'b0;
    end else begin
      if (m == 2'd1) m_q = {m_q[W-2:0], fl};
      else           m_q = {fr, m_q[W-1:1]};
      if (int'(m_cnt) == W - 1) begin
        m_cnt = '0; m_done = 1'b1;
      end else begin
        m_cnt = m_cnt + 1'b1; m_done = 1'b0;
      end
    end
    x.q = m_q; x.cnt = m_cnt; x.done = m_done;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_val("q",         32'(q),         32'(mon_e.q));
      check_val("cnt",       32'(cnt),       32'(mon_e.cnt));
      check_val("word_done", 32'(word_done), 32'(mon_e.done));
      check_val("sout_msb",  32'(sout_msb),  32'(mon_e.q[W-1]));
      check_val("sout_lsb",  32'(sout_lsb),  32'(mon_e.q[0]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] sipo_bits;
    logic [3:0] piso_exp;
`ifdef SHIFT_REG_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    rst = 1'b1; en = 1'b1; mode = 2'd3; sin_lsb = 1'b0; sin_msb = 1'b0;
    rot = 1'b0; par_in = 4'hF;

    // Reset overrides LOAD.
    step(1, 1, 2'd3, 0, 0, 0, 4'hF);
    step(1, 1, 2'd3, 0, 0, 0, 4'hF);
    check_val("rst_q", 32'(q), 32'h0);
    check_val("rst_cnt", 32'(cnt), 32'h0);
    check_val("rst_done", 32'(word_done), 32'h0);

    // SIPO: 1,0,1,1 into the LSB.
    sipo_bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'd1, sipo_bits[i], 0, 0, '0);
      check_val("sipo_cnt", 32'(cnt), 32'((i + 1) % 4));
      check_val("sipo_done", 32'(word_done), 32'(i == 3));
    end
    check_val("sipo_q", 32'(q), 32'b1011);
    step(0, 1, 2'd0, 0, 0, 0, '0);
    check_val("hold_done_low", 32'(word_done), 32'h0);

    // PISO: load then shift right out of the LSB.
    piso_exp = 4'b1001;
    step(0, 1, 2'd3, 0, 0, 0, 4'b1001);
    check_val("piso_load_cnt", 32'(cnt), 32'h0);
    check_val("piso_sout0", 32'(sout_lsb), 32'(piso_exp[3]));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'd2, 0, 0, 0, '0);
      if (i < 3) check_val("piso_sout", 32'(sout_lsb), 32'(piso_exp[2-i]));
    end
    check_val("piso_done", 32'(word_done), 32'h1);

    // Enable/hold across a word.
    step(0, 1, 2'd3, 0, 0, 0, 4'h0);
    step(0, 1, 2'd1, 1, 0, 0, '0);
    step(0, 1, 2'd1, 1, 0, 0, '0);
    step(0, 0, 2'd1, 0, 0, 0, '0);
    step(0, 0, 2'd3, 0, 0, 0, 4'hA);
    step(0, 1, 2'd0, 0, 0, 0, '0);
    check_val("hold_q", 32'(q), 32'b0011);
    check_val("hold_cnt", 32'(cnt), 32'h2);
    step(0, 1, 2'd1, 0, 0, 0, '0);
    step(0, 1, 2'd1, 1, 0, 0, '0);
    check_val("hold_word_q", 32'(q), 32'b1101);
    check_val("hold_word_done", 32'(word_done), 32'h1);

    // Reset part-way through a word.
    for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 1, 0, 0, '0);
    step(1, 1, 2'd1, 1, 0, 0, '0);
    check_val("midrst_q", 32'(q), 32'h0);
    check_val("midrst_cnt", 32'(cnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (i % 2 == 0) ? 2'd1 : 2'd2, 1, 1, 0, '0);
      check_val("midrst_done", 32'(word_done), 32'(i == 3));
    end

    // Rotate, or plain serial fill when rotate is compiled out.
    step(0, 1, 2'd3, 0, 0, 0, 4'b1000);
    step(0, 1, 2'd1, 0, 0, 1, '0);
    check_val("rot_shl", 32'(q), rot_en ? 32'b0001 : 32'b0000);
    step(0, 1, 2'd2, 0, 0, 1, '0);
    check_val("rot_shr", 32'(q), rot_en ? 32'b1000 : 32'b0000);

    // Back-to-back words.
    step(0, 1, 2'd3, 0, 0, 0, 4'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2'd1, i[0], 0, 0, '0);
      check_val("b2b_done", 32'(word_done), 32'((i % 4) == 3));
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
           W'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check_val("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: a WIDTH-bit register with hold, shift-left, shift-right and parallel-load modes, a clock enable, serial in/out on both ends and a shift counter that flags each completed word. It is the general-purpose successor to the fixed 4-bit SIPO stage. It serves as the serial/parallel converter for bring-up peripherals: UART-style SIPO/PISO, SPI shifting, and LED/GPIO expansion chains.

## Interface
Parameters:
- WIDTH, 4: register width in bits; legal range 2..32.
- RESET_VAL, '0: value loaded into q on reset, WIDTH bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; when 0, all state holds regardless of mode.
- mode  in  2  0=HOLD, 1=SHL, 2=SHR, 3=LOAD.
- sin_lsb  in  1  serial input that enters q[0] on SHL.
- sin_msb  in  1  serial input that enters q[WIDTH-1] on SHR.
- rot  in  1  rotate select; only honoured when SHIFT_REG_ROTATE_EN is defined.
- par_in  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents (parallel out).
- sout_msb  out  1  equals q[WIDTH-1]; combinational from the register.
- sout_lsb  out  1  equals q[0]; combinational from the register.
- cnt  out  $clog2(WIDTH)  number of shifts since the last load, reset or wrap.
- word_done  out  1  one-cycle pulse; q holds a complete shifted word.

## Operation
- Reset (rst=1 at an edge): q<=RESET_VAL, cnt<=0, word_done<=0. Reset overrides en and mode and may interrupt a word part-way. Any partial count is discarded.
- en=0: q and cnt hold. word_done<=0.
- HOLD: q and cnt hold. word_done<=0.
- SHL: q<={q[WIDTH-2:0], sin_lsb}. Data moves from the LSB toward the MSB, matching the legacy SIPO order.
- SHR: q<={sin_msb, q[WIDTH-1:1]}.
- LOAD: q<=par_in, cnt<=0, word_done<=0.
- Counter, on SHL or SHR with en=1:
  - if cnt==WIDTH-1, then cnt<=0 and word_done<=1;
  - otherwise cnt<=cnt+1 and word_done<=0.
- A mode change between SHL and SHR does not reset cnt. Shifts in either direction count toward the same word.
- cnt arithmetic is unsigned and wraps only through the explicit WIDTH-1 compare. For non-power-of-2 WIDTH, cnt never exceeds WIDTH-1.

## Timing
- Latency: the q update is visible one cycle after the sampling edge. sout_* follows q in the same cycle.
- word_done is registered. It is high exactly in the cycle after the edge that performed the WIDTH-th shift, which is the same cycle q first shows the full word. It is low in every other cycle.
- Back-to-back words: continuous shifting gives a word_done pulse every WIDTH cycles with no gap cycle.
- No handshake. The consumer must sample q while word_done=1, or issue HOLD/en=0 to freeze it.
- Simultaneous events, in priority order: rst > en=0 > mode.

## Configuration
- Macro: SHIFT_REG_ROTATE_EN.
- Defined: when rot=1, SHL feeds q[WIDTH-1] into q[0] instead of sin_lsb, and SHR feeds q[0] into q[WIDTH-1] instead of sin_msb. Counting and word_done are unchanged.
- Undefined: the rot port exists but is ignored, and no rotate muxes are synthesised.

## Structure
- Package shift_reg_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD};
  - a function for the counter width, clog2 with a minimum of 1.
- Sub-module shift_cell: one bit consisting of a 4:1 next-state mux (hold, left neighbour, right neighbour, par_in bit) feeding a flop with sync reset and enable. It is instantiated WIDTH times by a generate loop.
- The top level holds the edge-bit serial/rotate muxes, the counter and word_done.

## Test plan
- Reset: drive rst=1 with mode=LOAD, par_in=4'hF. Expect q=4'h0, cnt=0, word_done=0 after the edge.
- SIPO: WIDTH=4, SHL with sin_lsb=1,0,1,1 on four consecutive edges. Expect q=4'b1011, with word_done=1 only in the cycle after the 4th edge, and cnt 1,2,3,0.
- PISO: LOAD 4'b1001, then 4×SHR. sout_lsb must read 1,0,0,1 across the cycles starting at the load result. Expect cnt=0 after the load and a word_done pulse after the 4th shift.
- Enable/hold: shift 2 bits, hold for 3 cycles with en=0 or HOLD, then shift 2 more. Expect q and cnt frozen during the hold, and word_done on the 4th shift.
- Reset mid-word: assert rst after 3 shifts. Expect q=RESET_VAL and cnt=0. A new word then needs 4 full shifts before word_done.
- Rotate (macro defined): LOAD 4'b1000, rot=1, SHL ×1. Expect q=4'b0001. Then SHR ×1, expect q=4'b1000. With the macro undefined, the same SHL stimulus with sin_lsb=0 gives q=4'b0000.
